instr_fetch: RTL
================

# instr_fetch

Instruction fetch stage sitting directly upstream of the 17-bit instruction memory. It owns the program counter and drives the memory's address and read enable. It captures the word the memory returns (read on the falling clock edge) into the IF/ID pipeline register, along with the PC and PC+1. It also handles pipeline stall, branch/jump redirect (flush) and halt detection.

## Interface
Parameters:
- PC_W, 16, program counter / memory address width (word addressed)
- INSTR_W, 17, instruction width
- RESET_PC, 16'h0000, PC value loaded on reset
- HALT_OPCODE, 5'h1F, value of instr[16:12] that identifies HLT
- NOP_INSTR, 17'h00000, instruction inserted into IF/ID on a bubble

Ports:
- clk  in  1  system clock; all state updates on posedge
- rst_n  in  1  synchronous, active-low reset
- stall  in  1  hold PC and IF/ID (hazard unit)
- flush  in  1  redirect fetch to branch_target and squash the current fetch (from EX)
- branch_target  in  PC_W  redirect address, valid when flush=1
- im_addr  out  PC_W  instruction memory address, equals pc
- im_rd_en  out  1  instruction memory read enable
- im_instr  in  INSTR_W  instruction memory data, updated by memory on negedge
- ifid_instr  out  INSTR_W  registered instruction to decode
- ifid_pc  out  PC_W  address of ifid_instr
- ifid_pc_inc  out  PC_W  ifid_pc + 1 (link / branch base)
- ifid_vld  out  1  ifid_* hold a real, in-path instruction
- halted  out  1  HLT fetched; fetch stopped

## Operation
- im_addr = pc, combinational.
- im_rd_en = rst_n & ~stall & ~halted, combinational.
- Fetch cycle: with im_rd_en=1 in cycle k, memory reads mem[pc] on the negedge in cycle k. At the posedge ending cycle k the stage loads:
  - ifid_instr <= im_instr
  - ifid_pc <= pc
  - ifid_pc_inc <= pc+1
  - ifid_vld <= 1
  - pc <= pc+1
- Priority at each posedge (highest first): reset, flush, stall, halted, normal fetch.
- Reset (rst_n=0 at posedge):
  - pc=RESET_PC
  - ifid_instr=NOP_INSTR, ifid_pc=0, ifid_pc_inc=0, ifid_vld=0
  - halted=0
  - im_rd_en=0 while rst_n=0
- Flush:
  - pc <= branch_target
  - ifid_instr <= NOP_INSTR, ifid_vld <= 0
  - halted <= 0
  - The memory read in that cycle is discarded.
  - Overrides a simultaneous stall.
- Stall (no flush): pc and all ifid_* hold. Memory holds its output because im_rd_en=0.
- Halt: on a normal fetch where im_instr[16:12]==HALT_OPCODE:
  - The HLT word is captured normally (ifid_vld=1) and pc advances.
  - halted <= 1 in the same posedge.
  - While halted (no flush), pc holds, and ifid_instr <= NOP_INSTR, ifid_vld <= 0 from the next posedge on.
  - halted leaves only via reset or flush.
- PC arithmetic is modulo 2^PC_W: 16'hFFFF+1 wraps to 16'h0000, and the same applies to ifid_pc_inc. The stage does no range check against memory depth.

## Timing
- Fetch latency: address presented in cycle k → instruction valid on ifid_* after the posedge ending cycle k (one cycle).
- Throughput: one instruction per cycle while not stalled or halted.
- Flush in cycle k:
  - ifid_vld=0 after the posedge ending cycle k.
  - branch_target is fetched in cycle k+1 and is valid on ifid_* after cycle k+1.
  - Branch penalty is the one squashed slot plus whatever the upstream redirect timing adds.
- Stall asserted cycles k..k+n: ifid_* and pc are unchanged through the posedge ending cycle k+n. Fetch resumes in cycle k+n+1 at the held pc.
- Reset mid-stream:
  - The posedge with rst_n=0 discards any in-flight fetch.
  - The first fetch is of RESET_PC, in the first cycle with rst_n=1.

## Test plan
- Sequential fetch: reset, release, mem[0..3]=17'h01111,17'h02222,17'h03333,17'h04444. Over 4 cycles, ifid_instr follows that sequence, ifid_pc=0..3, ifid_pc_inc=1..4, and ifid_vld=1 from the first posedge after release.
- Stall: stall=1 for 3 cycles after pc=2. ifid holds mem[1] with ifid_pc=1, im_rd_en=0, pc stays 2. After release, the next ifid_pc=2 with no skipped or duplicated instruction.
- Flush with simultaneous stall: flush=1, stall=1, branch_target=16'h0040 at pc=5. The next posedge gives ifid_vld=0, ifid_instr=NOP_INSTR, pc=16'h0040. The following cycle gives ifid_pc=16'h0040 with mem[16'h0040].
- Halt: mem[3]=17'h1F000. The cycle after capture shows ifid_instr=17'h1F000, ifid_vld=1, halted=1. After that, im_rd_en=0, ifid_vld=0 and pc=4 indefinitely. A later flush to 16'h0010 clears halted and fetch resumes at 16'h0010.
- Wrap: flush to 16'hFFFF, then run two cycles. ifid_pc=16'hFFFF with ifid_pc_inc=16'h0000, then ifid_pc=16'h0000.
- Reset mid-operation: assert rst_n=0 for one posedge at pc=16'h0123 during stall. All outputs return to reset values, halted=0, and the first fetch after release is RESET_PC.

Source files
------------

// File: rtl/instr_fetch_if.sv
// Instruction memory bus between the fetch stage (master) and the instruction memory (slave).
interface instr_fetch_if #(
  parameter int PC_W    = 16,
  parameter int INSTR_W = 17
);
  logic [PC_W-1:0]    im_addr;
  logic               im_rd_en;
  logic [INSTR_W-1:0] im_instr;

  modport master (output im_addr, output im_rd_en, input im_instr);
  modport slave  (input im_addr, input im_rd_en, output im_instr);
endinterface

// File: rtl/instr_fetch.sv
// Instruction fetch stage: owns the PC, drives the instruction memory and loads the IF/ID
// register, with stall, flush (branch redirect) and HLT detection.
module instr_fetch #(
  parameter int                  PC_W        = 16,
  parameter int                  INSTR_W     = 17,
  parameter logic [PC_W-1:0]     RESET_PC    = 16'h0000,
  parameter logic [4:0]          HALT_OPCODE = 5'h1F,
  parameter logic [INSTR_W-1:0]  NOP_INSTR   = 17'h00000
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               stall,
  input  logic               flush,
  input  logic [PC_W-1:0]    branch_target,
  instr_fetch_if.master      imem,
  output logic [INSTR_W-1:0] ifid_instr,
  output logic [PC_W-1:0]    ifid_pc,
  output logic [PC_W-1:0]    ifid_pc_inc,
  output logic               ifid_vld,
  output logic               halted
);

  logic [PC_W-1:0] pc;
  logic [PC_W-1:0] pc_inc;
  logic            is_halt;

  // Modulo 2^PC_W: 16'hFFFF + 1 wraps to 0 with no range check.
  assign pc_inc  = pc + PC_W'(1);
  assign is_halt = (imem.im_instr[INSTR_W-1 -: 5] == HALT_OPCODE);

  assign imem.im_addr  = pc;
  assign imem.im_rd_en = rst_n & ~stall & ~halted;

  // NOTE: reset is sampled on the clock edge (synchronous), and all state uses
  // non-blocking assignments so every register sees pre-edge values of the others.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      pc          <= RESET_PC;
      ifid_instr  <= NOP_INSTR;
      ifid_pc     <= '0;
      ifid_pc_inc <= '0;
      ifid_vld    <= 1'b0;
      halted      <= 1'b0;
    end else if (flush) begin
      // Redirect wins over stall; whatever the memory returned this cycle is dropped.
      pc         <= branch_target;
      ifid_instr <= NOP_INSTR;
      ifid_vld   <= 1'b0;
      halted     <= 1'b0;
    end else if (stall) begin
      pc <= pc;
    end else if (halted) begin
      ifid_instr <= NOP_INSTR;
      ifid_vld   <= 1'b0;
    end else begin
      ifid_instr  <= imem.im_instr;
      ifid_pc     <= pc;
      ifid_pc_inc <= pc_inc;
      ifid_vld    <= 1'b1;
      pc          <= pc_inc;
      // The HLT word itself still enters decode; only later fetches stop.
      if (is_halt) halted <= 1'b1;
    end
  end

endmodule
